usb_piso_tx: RTL and testbench

USB_PISO_TX -- requirements
Module: usb_piso_tx

---
 rtl/usb_tx_pkg.sv | 17 +
 rtl/usb_nrzi_enc.sv | 30 +++
 rtl/usb_piso_tx.sv | 136 +++++++++++++
 tb/tb_usb_piso_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB serial transmitter: FSM encoding, idle line
// level and default geometry.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STUFF = 2'd2
  } tx_state_e;

  // J state: the idle line level and the NRZI reference at packet start.
  localparam logic J_LEVEL = 1'b1;

  localparam int DEFAULT_DATA_W    = 8;
  localparam int DEFAULT_STUFF_LEN = 6;

endpackage

// File: rtl/usb_nrzi_enc.sv
// NRZI line-level register: a 0 bit toggles the level, a 1 bit holds it, and
// restart returns the line to J ready for the next packet.
module usb_nrzi_enc
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic data_bit_i,
  input  logic en_i,
  input  logic restart_i,
  output logic level_o
);

  logic level_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= J_LEVEL;
    end else if (restart_i) begin
      level_q <= J_LEVEL;
    end else if (en_i && !data_bit_i) begin
      level_q <= ~level_q;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/usb_piso_tx.sv
// Parallel-in serial-out USB transmitter: LSB-first shift, NRZI line coding and
// optional bit stuffing, compiled in when USB_BIT_STUFF_EN is defined.
module usb_piso_tx
  import usb_tx_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int STUFF_LEN = DEFAULT_STUFF_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] parallel_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              serial_out,
  output logic              tx_active
);

  localparam int                CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  FIRST_CNT = CNT_W'(1);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              tx_active_q;

  logic byte_done;
  logic accept;
  logic go_idle;
  logic emit_en;
  logic emit_bit;
  logic stuff_hit;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    byte_done  = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT);
    load_ready = (state_q == ST_IDLE) || byte_done;
    accept     = load_valid && load_ready;
    go_idle    = byte_done && !load_valid;
    emit_en    = 1'b0;
    emit_bit   = 1'b0;
    if (accept) begin
      // Bit 0 goes out on the acceptance edge itself.
      emit_en  = 1'b1;
      emit_bit = parallel_in[0];
    end else if ((state_q == ST_SHIFT) && !byte_done) begin
      emit_en  = 1'b1;
      emit_bit = shift_q[0];
`ifdef USB_BIT_STUFF_EN
    end else if (state_q == ST_STUFF) begin
      emit_en  = 1'b1;
      emit_bit = 1'b0;
`endif
    end
  end

`ifdef USB_BIT_STUFF_EN
  localparam int                ONES_W    = $clog2(STUFF_LEN + 1);
  localparam logic [ONES_W-1:0] STUFF_CNT = ONES_W'(STUFF_LEN);

  logic [ONES_W-1:0] ones_cnt_q;
  logic [ONES_W-1:0] ones_cnt_d;

  // The run of ones spans byte boundaries; only a 0, a stuff bit or the end
  // of the packet breaks it.
  always_comb begin
    ones_cnt_d = ones_cnt_q;
    if (go_idle) begin
      ones_cnt_d = '0;
    end else if (emit_en) begin
      ones_cnt_d = emit_bit ? ones_cnt_q + 1'b1 : '0;
    end
  end

  assign stuff_hit = emit_en && emit_bit && (ones_cnt_d == STUFF_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt_q <= '0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
    end
  end
`else
  logic unused_stuff_len;
  assign unused_stuff_len = (STUFF_LEN > 0);
  assign stuff_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tx_active_q <= 1'b0;
    end else if (accept) begin
      shift_q     <= parallel_in >> 1;
      bit_cnt_q   <= FIRST_CNT;
      tx_active_q <= 1'b1;
      state_q     <= stuff_hit ? ST_STUFF : ST_SHIFT;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (go_idle) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tx_active_q <= 1'b0;
          end else begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (stuff_hit) begin
              state_q <= ST_STUFF;
            end
          end
        end
`ifdef USB_BIT_STUFF_EN
        ST_STUFF: state_q <= ST_SHIFT;
`endif
        default: ;
      endcase
    end
  end

  usb_nrzi_enc u_nrzi (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_bit_i(emit_bit),
    .en_i      (emit_en),
    .restart_i (go_idle),
    .level_o   (serial_out)
  );

  assign tx_active = tx_active_q;

endmodule

// File: tb/tb_usb_piso_tx.sv
// Self-checking bench for usb_piso_tx; expectations follow USB_BIT_STUFF_EN.
module tb_usb_piso_tx;

  localparam int DATA_W    = 8;
  localparam int STUFF_LEN = 6;

`ifdef USB_BIT_STUFF_EN
  localparam bit          STUFF_ON  = 1'b1;
  localparam logic [31:0] FF_EXP    = 32'b111111000;
  localparam int          FF_LEN    = 9;
  localparam logic [31:0] F003_EXP  = 32'b01011111110101010;
  localparam int          F003_LEN  = 17;
`else
  localparam bit          STUFF_ON  = 1'b0;
  localparam logic [31:0] FF_EXP    = 32'b11111111;
  localparam int          FF_LEN    = 8;
  localparam logic [31:0] F003_EXP  = 32'b0101111111010101;
  localparam int          F003_LEN  = 16;
`endif

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] parallel_in;
  logic              load_valid;
  logic              load_ready;
  logic              serial_out;
  logic              tx_active;

  int n_checks;
  int n_errors;

  logic       cmp_en;
  logic [7:0] pkt [4];
  int         pkt_n;
  bit         exp_lvl_q [$];
  bit         exp_rdy_q [$];
  bit         cap_lvl [$];
  bit         cap_rdy [$];

  usb_piso_tx #(
    .DATA_W   (DATA_W),
    .STUFF_LEN(STUFF_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .parallel_in(parallel_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .serial_out (serial_out),
    .tx_active  (tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: bit list LSB first, stuff after STUFF_LEN ones in a row across
  // the whole packet, then NRZI from J. The last line cycle of each byte is the
  // cycle in which the next byte may be offered.
  task automatic build_expected();
    bit lvl;
    int ones;
    lvl  = 1'b1;
    ones = 0;
    for (int i = 0; i < pkt_n; i++) begin
      for (int k = 0; k < DATA_W; k++) begin
        bit b;
        b = pkt[i][k];
        if (!b) lvl = ~lvl;
        exp_lvl_q.push_back(lvl);
        exp_rdy_q.push_back(1'b0);
        ones = b ? ones + 1 : 0;
        if (STUFF_ON && ones == STUFF_LEN) begin
          lvl = ~lvl;
          exp_lvl_q.push_back(lvl);
          exp_rdy_q.push_back(1'b0);
          ones = 0;
        end
      end
      exp_rdy_q[exp_rdy_q.size()-1] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      if (exp_lvl_q.size() > 0) begin
        bit e_l;
        bit e_r;
        e_l = exp_lvl_q.pop_front();
        e_r = exp_rdy_q.pop_front();
        check("line_level", serial_out, e_l);
        check("tx_active", tx_active, 1);
        check("load_ready", load_ready, e_r);
        cap_lvl.push_back(serial_out);
        cap_rdy.push_back(load_ready);
      end else begin
        check("idle_level", serial_out, 1);
        check("idle_active", tx_active, 0);
        check("idle_ready", load_ready, 1);
      end
    end
  end

  // Streams pkt[0..pkt_n-1] with load_valid held; optionally wiggles
  // load_valid with junk data while the byte is still shifting.
  task automatic send_packet(input bit glitch);
    int wait_cnt;
    cap_lvl.delete();
    cap_rdy.delete();
    for (int i = 0; i < pkt_n; i++) begin
      @(negedge clk);
      parallel_in = pkt[i];
      load_valid  = 1'b1;
      #1;
      wait_cnt = 0;
      while (!load_ready && wait_cnt < 40) begin
        @(negedge clk);
        #1;
        wait_cnt++;
      end
      check("accept_ready", load_ready, 1);
      @(posedge clk);
      if (i == 0) build_expected();
    end
    @(negedge clk);
    load_valid  = 1'b0;
    parallel_in = '0;
    if (glitch) begin
      repeat (2) @(negedge clk);
      parallel_in = 8'hFF;
      load_valid  = 1'b1;
      repeat (3) @(negedge clk);
      load_valid  = 1'b0;
      parallel_in = '0;
    end
    wait_cnt = 0;
    while (exp_lvl_q.size() > 0 && wait_cnt < 60) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("drain_done", exp_lvl_q.size(), 0);
    exp_lvl_q.delete();
    exp_rdy_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_seq(input string name, input bit use_rdy,
                           input logic [31:0] exp_vec, input int len);
    logic [31:0] act;
    int sz;
    act = '0;
    sz  = use_rdy ? cap_rdy.size() : cap_lvl.size();
    check({name, "_len"}, sz, len);
    for (int i = 0; i < sz && i < 32; i++) begin
      act = {act[30:0], (use_rdy ? cap_rdy[i] : cap_lvl[i])};
    end
    check(name, act, exp_vec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    cmp_en      = 1'b0;
    rst_n       = 1'b0;
    load_valid  = 1'b0;
    parallel_in = '0;
    pkt_n       = 0;
    for (int i = 0; i < 4; i++) pkt[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_level", serial_out, 1);
    check("rst_active", tx_active, 0);
    check("rst_ready", load_ready, 1);
    rst_n = 1'b1;
    #1;
    check("release_ready", load_ready, 1);
    cmp_en = 1'b1;

    pkt[0] = 8'hFF; pkt_n = 1;
    send_packet(1'b0);
    check_seq("ff_line", 1'b0, FF_EXP, FF_LEN);

    pkt[0] = 8'h00; pkt_n = 1;
    send_packet(1'b1);
    check_seq("zero_line", 1'b0, 32'b01010101, 8);

    pkt[0] = 8'hA5; pkt[1] = 8'h3C; pkt_n = 2;
    send_packet(1'b0);
    check_seq("a53c_line", 1'b0, 32'b1001001101111101, 16);
    check_seq("a53c_ready", 1'b1, 32'b0000000100000001, 16);

    pkt[0] = 8'hF0; pkt[1] = 8'h03; pkt_n = 2;
    send_packet(1'b0);
    check_seq("f003_line", 1'b0, F003_EXP, F003_LEN);

    pkt[0] = 8'hFF; pkt[1] = 8'hFF; pkt[2] = 8'h7F; pkt_n = 3;
    send_packet(1'b0);

    // Reset in the middle of 0x5A, after line bit 1 (level 0) and bit 4 (level 1).
    for (int r = 0; r < 2; r++) begin
      int   pos;
      logic exp_lv;
      pos    = (r == 0) ? 1 : 4;
      exp_lv = (r == 0) ? 1'b0 : 1'b1;
      cmp_en = 1'b0;
      @(negedge clk);
      parallel_in = 8'h5A;
      load_valid  = 1'b1;
      #1;
      check("rst_case_ready", load_ready, 1);
      @(posedge clk);
      #1;
      load_valid  = 1'b0;
      parallel_in = '0;
      repeat (pos) @(posedge clk);
      @(negedge clk);
      check("mid_byte_active", tx_active, 1);
      check("mid_byte_level", serial_out, exp_lv);
      rst_n = 1'b0;
      #1;
      check("async_rst_level", serial_out, 1);
      check("async_rst_active", tx_active, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", load_ready, 1);
      @(posedge clk);
      #1;
      check("no_residual_level", serial_out, 1);
      check("no_residual_active", tx_active, 0);
      @(negedge clk);
      cmp_en = 1'b1;
    end

    pkt[0] = 8'h5A; pkt_n = 1;
    send_packet(1'b0);
    check_seq("5a_line", 1'b0, 32'b00111001, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
